// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, types and helpers for the ALU
//
// Purpose : data width, 4-bit operation codes, shifter mode type and a
//           bit-reversal helper used to share one right-shift datapath.
// Ports   : none (package)

package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10
  } shiftMode_e;

  // Left shift is done as reverse -> right shift -> reverse so that the
  // barrel shifter only needs one direction of muxing.
  function automatic logic [XLEN-1:0] bitReverse(input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = d[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - 5-stage logarithmic barrel shifter (SLL/SRL/SRA)
//
// Purpose : shift data by shamt using five mux stages of 1/2/4/8/16 bits.
// Ports   : data   in  [XLEN-1:0] value to shift
//           shamt  in  [4:0]      shift amount
//           mode   in  [1:0]      SHIFT_SLL / SHIFT_SRL / SHIFT_SRA
//           result out [XLEN-1:0] shifted value

module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [4:0]      shamt,
  input  shiftMode_e      mode,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] stage [0:5];
  logic            fill;

  // Only arithmetic right shift replicates the sign; everything else zero-fills.
  assign fill     = (mode == SHIFT_SRA) & data[XLEN-1];
  assign stage[0] = (mode == SHIFT_SLL) ? bitReverse(data) : data;

  for (genvar k = 0; k < 5; k++) begin : gStage
    localparam int STEP = 2 ** k;
    assign stage[k+1] = shamt[k] ? {{STEP{fill}}, stage[k][XLEN-1:STEP]} : stage[k];
  end

  assign result = (mode == SHIFT_SLL) ? bitReverse(stage[5]) : stage[5];

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32-style ALU with a registered result copy
//
// Purpose : ADD/SUB/SLT/SLTU/XOR/OR/AND/SLL/SRL/SRA/LUI on 32-bit operands.
// Ports   : i_clk       in  clock for the registered result only
//           i_reset     in  asynchronous active-high reset of o_aluData_q
//           i_operandA  in  [31:0] rs1 or PC
//           i_operandB  in  [31:0] rs2 or immediate
//           i_aluOp     in  [3:0]  operation select
//           o_aluData   out [31:0] combinational result
//           o_aluData_q out [31:0] o_aluData registered on i_clk

module alu
  import alu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [XLEN-1:0] i_operandA,
  input  logic [XLEN-1:0] i_operandB,
  input  logic [3:0]      i_aluOp,
  output logic [XLEN-1:0] o_aluData,
  output logic [XLEN-1:0] o_aluData_q
);

  logic [XLEN:0]   diff;
  logic            ltUnsigned;
  logic            ltSigned;
  logic [XLEN-1:0] shiftResult;
  shiftMode_e      shiftMode;

  // One 33-bit subtractor serves SUB, SLT and SLTU. Bit XLEN is the carry
  // out of A + ~B + 1, which is set exactly when A >= B unsigned.
  assign diff       = {1'b0, i_operandA} + {1'b0, ~i_operandB} + {{XLEN{1'b0}}, 1'b1};
  assign ltUnsigned = ~diff[XLEN];
  // With differing signs the negative operand is smaller and the difference
  // may overflow, so the sign of A decides; otherwise the difference sign does.
  assign ltSigned   = (i_operandA[XLEN-1] != i_operandB[XLEN-1]) ? i_operandA[XLEN-1]
                                                                 : diff[XLEN-1];

  assign shiftMode = (i_aluOp == ALU_SRA) ? SHIFT_SRA :
                     (i_aluOp == ALU_SRL) ? SHIFT_SRL : SHIFT_SLL;

  alu_shifter uShifter (
    .data   (i_operandA),
    .shamt  (i_operandB[4:0]),
    .mode   (shiftMode),
    .result (shiftResult)
  );

  always_comb begin
    o_aluData = '0;
    case (i_aluOp)
      ALU_ADD:  o_aluData = i_operandA + i_operandB;
      ALU_SUB:  o_aluData = diff[XLEN-1:0];
      ALU_SLT:  o_aluData = {{(XLEN-1){1'b0}}, ltSigned};
      ALU_SLTU: o_aluData = {{(XLEN-1){1'b0}}, ltUnsigned};
      ALU_XOR:  o_aluData = i_operandA ^ i_operandB;
      ALU_OR:   o_aluData = i_operandA | i_operandB;
      ALU_AND:  o_aluData = i_operandA & i_operandB;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  o_aluData = shiftResult;
      ALU_LUI:  o_aluData = i_operandB;
      default:  o_aluData = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_aluData_q <= '0;
    end else begin
      o_aluData_q <= o_aluData;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu (vector table + scoreboard)

module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [3:0]  op;
  logic [31:0] aluData;
  logic [31:0] aluDataQ;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] regQueue[$];

  alu dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_operandA  (opA),
    .i_operandB  (opB),
    .i_aluOp     (op),
    .o_aluData   (aluData),
    .o_aluData_q (aluDataQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model written with the plain operators.
  function automatic logic [31:0] refModel(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    case (o)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return a | b;
      4'd6:    return a & b;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return $unsigned($signed(a) >>> b[4:0]);
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  // Drive at the falling edge, check the combinational result, queue the
  // expected register value and check it after the next rising edge.
  task automatic applyVec(input string name, input vec_t v);
    logic [31:0] expQ;
    @(negedge clk);
    op  = v.op;
    opA = v.a;
    opB = v.b;
    regQueue.push_back(v.exp);
    #1;
    check(name, aluData, v.exp);
    @(posedge clk);
    #1;
    if (regQueue.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_q: scoreboard empty, got %08h", name, aluDataQ);
    end else begin
      expQ = regQueue.pop_front();
      check({name, "_q"}, aluDataQ, expQ);
    end
  endtask

  initial begin
    // Directed vector table.
    vecs.push_back('{4'd0,  32'd15,        32'd10,        32'd25});
    vecs.push_back('{4'd1,  32'd15,        32'd10,        32'd5});
    vecs.push_back('{4'd1,  32'd50,        32'd50,        32'd0});
    vecs.push_back('{4'd0,  32'h7FFFFFFE,  32'h1,         32'h7FFFFFFF});
    vecs.push_back('{4'd0,  32'hFFFFFFFF,  32'h1,         32'h0});
    vecs.push_back('{4'd1,  32'd10,        32'd20,        32'hFFFFFFF6});
    vecs.push_back('{4'd2,  32'd10,        32'd15,        32'd1});
    vecs.push_back('{4'd3,  32'd10,        32'd15,        32'd1});
    vecs.push_back('{4'd2,  32'd20,        32'd15,        32'd0});
    vecs.push_back('{4'd3,  32'd20,        32'd15,        32'd0});
    vecs.push_back('{4'd2,  32'hFFFFFFFF,  32'h0,         32'd1});
    vecs.push_back('{4'd3,  32'hFFFFFFFF,  32'h0,         32'd0});
    vecs.push_back('{4'd2,  32'hFFFFFFFF,  32'hFFFFFFFE,  32'd0});
    vecs.push_back('{4'd3,  32'hFFFFFFFF,  32'hFFFFFFFE,  32'd0});
    vecs.push_back('{4'd2,  32'd5,         32'd5,         32'd0});
    vecs.push_back('{4'd3,  32'd5,         32'd5,         32'd0});
    vecs.push_back('{4'd2,  32'h80000000,  32'h7FFFFFFF,  32'd1});
    vecs.push_back('{4'd3,  32'h80000000,  32'h7FFFFFFF,  32'd0});
    vecs.push_back('{4'd4,  32'hFF00FF00,  32'h0F0F0F0F,  32'hF00FF00F});
    vecs.push_back('{4'd5,  32'hFF00FF00,  32'h0F0F0F0F,  32'hFF0FFF0F});
    vecs.push_back('{4'd6,  32'hFF00FF00,  32'h0F0F0F0F,  32'h0F000F00});
    vecs.push_back('{4'd6,  32'hABCDEF12,  32'h0,         32'h0});
    vecs.push_back('{4'd7,  32'h1,         32'd31,        32'h80000000});
    vecs.push_back('{4'd8,  32'd16,        32'd2,         32'd4});
    vecs.push_back('{4'd9,  32'hF0000000,  32'd4,         32'hFF000000});
    vecs.push_back('{4'd9,  32'h80000000,  32'd31,        32'hFFFFFFFF});
    vecs.push_back('{4'd7,  32'h1,         32'h00000021,  32'h2});
    vecs.push_back('{4'd8,  32'h80000000,  32'hFFFFFFE0,  32'h80000000});
    vecs.push_back('{4'd9,  32'h12345678,  32'h0,         32'h12345678});
    vecs.push_back('{4'd8,  32'h80000000,  32'd31,        32'h1});
    vecs.push_back('{4'd9,  32'h70000000,  32'd4,         32'h07000000});
    vecs.push_back('{4'd7,  32'h0000A5A5,  32'd8,         32'h00A5A500});
    vecs.push_back('{4'd10, 32'h12345678,  32'hDEADBEEF,  32'hDEADBEEF});
    vecs.push_back('{4'd11, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h0});
    vecs.push_back('{4'd12, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h0});
    vecs.push_back('{4'd13, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h0});
    vecs.push_back('{4'd14, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h0});
    vecs.push_back('{4'd15, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h0});

    // Reset: register held at zero across edges; combinational path unaffected.
    rst = 1'b1;
    op  = 4'd0;
    opA = 32'd15;
    opB = 32'd10;
    #1;
    check("reset_q_initial", aluDataQ, 32'h0);
    check("reset_comb_add", aluData, 32'd25);
    repeat (2) @(posedge clk);
    #1;
    check("reset_q_held", aluDataQ, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyVec($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i]);
    end

    // Random sweep against the reference model.
    for (int i = 0; i < 60; i++) begin
      vec_t r;
      r.op  = 4'($urandom_range(0, 15));
      r.a   = $urandom();
      r.b   = (i % 3 == 0) ? r.a : $urandom();
      r.exp = refModel(r.op, r.a, r.b);
      applyVec($sformatf("rand%0d_op%0d", i, r.op), r);
    end

    // Asynchronous reset mid-cycle with a nonzero registered value.
    applyVec("pre_reset_add", '{4'd0, 32'd15, 32'd10, 32'd25});
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_q", aluDataQ, 32'h0);
    check("async_reset_comb", aluData, 32'd25);
    @(posedge clk);
    #1;
    check("reset_q_over_edge", aluDataQ, 32'h0);

    // Release: register stays zero until the next edge, then tracks o_aluData.
    @(negedge clk);
    rst = 1'b0;
    op  = 4'd4;
    opA = 32'hFF00FF00;
    opB = 32'h0F0F0F0F;
    regQueue.push_back(32'hF00FF00F);
    #1;
    check("post_release_q_zero", aluDataQ, 32'h0);
    @(posedge clk);
    #1;
    if (regQueue.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL post_release_q: scoreboard empty, got %08h", aluDataQ);
    end else begin
      check("post_release_q", aluDataQ, regQueue.pop_front());
    end
    applyVec("post_release_sub", '{4'd1, 32'd10, 32'd20, 32'hFFFFFFF6});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL expose i_clk, input, 1 bit, single clock; only the registered output uses it.
REQ-002 The module SHALL expose i_reset, input, 1 bit, asynchronous active-high reset.
REQ-003 The module SHALL expose i_operandA, input, 32 bits, first operand (rs1 or PC).
REQ-004 The module SHALL expose i_operandB, input, 32 bits, second operand (rs2 or immediate).
REQ-005 The module SHALL expose i_aluOp, input, 4 bits, operation select.
REQ-006 The module SHALL expose o_aluData, output, 32 bits, combinational result.
REQ-007 The module SHALL expose o_aluData_q, output, 32 bits, o_aluData registered on the i_clk rising edge.

Function
REQ-008 The module SHALL compute o_aluData purely combinationally from i_operandA, i_operandB and i_aluOp, with zero-cycle latency and no dependence on i_clk or i_reset.
REQ-009 i_aluOp 0000 (ADD) SHALL give A+B modulo 2^32, discarding the carry (7FFFFFFE+1 = 7FFFFFFF; FFFFFFFF+1 = 0).
REQ-010 i_aluOp 0001 (SUB) SHALL give A-B modulo 2^32 (10-20 = FFFFFFF6).
REQ-011 i_aluOp 0010 (SLT) SHALL give 32'd1 if A < B as two's-complement signed values, else 0.
REQ-012 i_aluOp 0011 (SLTU) SHALL give 32'd1 if A < B as unsigned values, else 0.
REQ-013 For SLT and SLTU, A == B SHALL give 0.
REQ-014 For SUB, SLT and SLTU, the result SHALL come from one shared 33-bit subtractor (A + ~B + 1), not from separate comparators.
REQ-015 The SLT/SLTU flags SHALL be derived from the subtractor's carry, sign and operand signs.
REQ-016 i_aluOp 0100 SHALL give A^B, 0101 SHALL give A|B, and 0110 SHALL give A&B.
REQ-017 i_aluOp 0111 (SLL) SHALL give A shifted left by B[4:0], zero-filled.
REQ-018 i_aluOp 1000 (SRL) SHALL give A shifted right logically by B[4:0], zero-filled.
REQ-019 i_aluOp 1001 (SRA) SHALL give A shifted right by B[4:0], filled with A[31].
REQ-020 For all shifts, B[31:5] SHALL be ignored, and a shift amount of 0 SHALL return A unchanged.
REQ-021 i_aluOp 1010 (LUI) SHALL pass i_operandB through unchanged, ignoring A.
REQ-022 i_aluOp 1011 through 1111 SHALL give 32'h00000000.
REQ-023 o_aluData SHALL never be X or Z when all inputs are known.

Reset
REQ-024 While i_reset is high, o_aluData_q SHALL be 32'h00000000 immediately, independent of i_clk.
REQ-025 After i_reset deasserts, o_aluData_q SHALL load o_aluData on each i_clk rising edge.
REQ-026 i_reset SHALL have no effect on o_aluData.

Structure
REQ-027 Package alu_pkg SHALL hold the 4-bit opcode localparams: ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI.
REQ-028 alu_pkg SHALL hold the data-width constant XLEN = 32.
REQ-029 Shifting SHALL be done in sub-module alu_shifter, a 5-stage logarithmic barrel shifter.
REQ-030 alu_shifter SHALL take inputs data, shamt[4:0] and a 2-bit mode (SLL/SRL/SRA), and produce the shifted data.
REQ-031 The module SHALL NOT use the built-in <<, >>, >>> or < operators on 32-bit operands.

Verification
REQ-032 ADD and SUB: A=15, B=10 -> ADD gives 25 and SUB gives 5; A=B=50 with SUB -> 0.
REQ-033 SLT/SLTU: 10 vs 15 -> SLT 1 and SLTU 1; 20 vs 15 -> 0 and 0; FFFFFFFF vs 0 -> SLT 1 and SLTU 0; FFFFFFFF vs FFFFFFFE -> SLT 0 and SLTU 0.
REQ-034 Logic ops: A=FF00FF00, B=0F0F0F0F -> XOR F00FF00F, OR FF0FFF0F, AND 0F000F00; A=ABCDEF12 AND 0 -> 0.
REQ-035 Shifts: SLL 1 by 31 -> 80000000; SRL 16 by 2 -> 4; SRA F0000000 by 4 -> FF000000; SRA 80000000 by 31 -> FFFFFFFF; SLL with B=32'h00000021 -> shift by 1.
REQ-036 Misc ops: LUI with B=DEADBEEF -> DEADBEEF; op 1111 -> 0.
REQ-037 Register and reset: assert i_reset mid-operation with o_aluData_q nonzero -> o_aluData_q is 0 before the next i_clk edge.
REQ-038 After release of i_reset, o_aluData_q SHALL equal the prior-cycle o_aluData one i_clk edge later.
